// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential non-restoring divider: controller
// state encodings and the default operand width.
package seq_div_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DZ   = 2'd3
   } div_state_t;

endpackage

// File: rtl/seq_divider_div_row.sv
// Combinational WIDTH+1-bit controlled add/subtract row for the divider.
// add_bar = 1 subtracts the divisor, add_bar = 0 adds it.
module div_row #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH:0] operand,
   input  logic [WIDTH:0] divisor,
   input  logic           add_bar,
   output logic [WIDTH:0] sum,
   output logic           carry_out
);

   logic [WIDTH:0]   divisor_eff;
   logic [WIDTH+1:0] full_sum;

   always_comb begin
      divisor_eff = divisor ^ {(WIDTH+1){add_bar}};
      full_sum    = {1'b0, operand} + {1'b0, divisor_eff} + {{(WIDTH+1){1'b0}}, add_bar};
   end

   assign sum       = full_sum[WIDTH:0];
   assign carry_out = full_sum[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Sequential non-restoring unsigned divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_CHECK_EN adds a one-cycle zero-divisor shortcut (DZ).
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_BAR,
   input  logic             START,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER,
   output logic             DIV_ZERO
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   div_state_t state, state_next;

   logic [WIDTH:0]   p;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    cnt;
   logic             done_q;

   logic             load_op;
   logic             iter_step;
   logic             fix_step;
   logic             dz_step;

   logic [WIDTH:0]   row_op;
   logic             row_add_bar;
   logic [WIDTH:0]   row_sum;
   logic             row_cout;

   // The single row serves both ITER (shifted P, add/sub by sign) and FIX (P + D).
   always_comb begin
      row_op      = {p[WIDTH-1:0], a[WIDTH-1]};
      row_add_bar = ~p[WIDTH];
      if (state == FIX) begin
         row_op      = p;
         row_add_bar = 1'b0;
      end
   end

   div_row #(
      .WIDTH (WIDTH)
   ) u_row (
      .operand   (row_op),
      .divisor   ({1'b0, d}),
      .add_bar   (row_add_bar),
      .sum       (row_sum),
      .carry_out (row_cout)
   );

   always_ff @(posedge CLK) begin
      if (!RST_BAR) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load_op    = 1'b0;
      iter_step  = 1'b0;
      fix_step   = 1'b0;
      dz_step    = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               load_op    = 1'b1;
               state_next = ITER;
`ifdef DIV_ZERO_CHECK_EN
               if (DIVISOR == '0) begin
                  state_next = DZ;
               end
`endif
            end
         end
         ITER: begin
            iter_step = 1'b1;
            if (cnt == '0) begin
               state_next = FIX;
            end
         end
         FIX: begin
            fix_step   = 1'b1;
            state_next = IDLE;
         end
`ifdef DIV_ZERO_CHECK_EN
         DZ: begin
            dz_step    = 1'b1;
            state_next = IDLE;
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // a holds the dividend and fills with quotient bits from the LSB end.
   // Row carry-out equals the inverted sign of the new partial remainder.
   always_ff @(posedge CLK) begin
      if (!RST_BAR) begin
         p         <= '0;
         a         <= '0;
         d         <= '0;
         cnt       <= '0;
         done_q    <= 1'b0;
         QUOTIENT  <= '0;
         REMAINDER <= '0;
      end else begin
         done_q <= fix_step | dz_step;
         if (load_op) begin
            a   <= DIVIDEND;
            d   <= DIVISOR;
            p   <= '0;
            cnt <= CW'(WIDTH - 1);
         end
         if (iter_step) begin
            p   <= row_sum;
            a   <= {a[WIDTH-2:0], row_cout};
            cnt <= cnt - 1'b1;
         end
         if (fix_step) begin
            QUOTIENT <= a;
            if (p[WIDTH]) begin
               p         <= row_sum;
               REMAINDER <= row_sum[WIDTH-1:0];
            end else begin
               REMAINDER <= p[WIDTH-1:0];
            end
         end
         if (dz_step) begin
            QUOTIENT  <= '1;
            REMAINDER <= a;
         end
      end
   end

`ifdef DIV_ZERO_CHECK_EN
   logic div_zero_q;

   always_ff @(posedge CLK) begin
      if (!RST_BAR) begin
         div_zero_q <= 1'b0;
      end else if (fix_step) begin
         div_zero_q <= 1'b0;
      end else if (dz_step) begin
         div_zero_q <= 1'b1;
      end
   end

   assign DIV_ZERO = div_zero_q;
`else
   assign DIV_ZERO = 1'b0;
`endif

   assign BUSY = (state != IDLE);
   assign DONE = done_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8); honours DIV_ZERO_CHECK_EN.
module tb_seq_divider;

   localparam int unsigned W = 8;

   logic         CLK;
   logic         RST_BAR;
   logic         START;
   logic [W-1:0] DIVIDEND;
   logic [W-1:0] DIVISOR;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] QUOTIENT;
   logic [W-1:0] REMAINDER;
   logic         DIV_ZERO;

   int n_checks;
   int n_fail;

   seq_divider #(
      .WIDTH (W)
   ) dut (
      .CLK       (CLK),
      .RST_BAR   (RST_BAR),
      .START     (START),
      .DIVIDEND  (DIVIDEND),
      .DIVISOR   (DIVISOR),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .QUOTIENT  (QUOTIENT),
      .REMAINDER (REMAINDER),
      .DIV_ZERO  (DIV_ZERO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drives operands with START so the next rising edge is edge 0.
   task automatic launch(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
      DIVIDEND = dvd;
      DIVISOR  = dvs;
      START    = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   // Returns the edge index (relative to edge 0) on which DONE rose, -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLK);
         #1;
         if (DONE === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      RST_BAR  = 1'b0;
      START    = 1'b0;
      DIVIDEND = '0;
      DIVISOR  = '0;
      repeat (3) @(posedge CLK);
      #1;
      n_checks++;
      if ({BUSY, DONE, DIV_ZERO, QUOTIENT, REMAINDER} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b dz=%b q=%0d r=%0d, required all 0",
                  BUSY, DONE, DIV_ZERO, QUOTIENT, REMAINDER);
      end
      @(negedge CLK);
      RST_BAR = 1'b1;
   endtask

   task automatic test_basic;
      int lat;
      @(negedge CLK);
      launch(8'd100, 8'd7);
      n_checks++;
      if (BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy: got %b, required 1", BUSY);
      end
      wait_done(lat);
      n_checks++;
      if (lat != 9) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d, required 9", lat);
      end
      n_checks++;
      if (QUOTIENT !== 8'd14 || REMAINDER !== 8'd2 || DIV_ZERO !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: q=%0d r=%0d dz=%b busy=%b, required q=14 r=2 dz=0 busy=0",
                  QUOTIENT, REMAINDER, DIV_ZERO, BUSY);
      end
      @(posedge CLK);
      #1;
      n_checks++;
      if (DONE !== 1'b0 || QUOTIENT !== 8'd14 || REMAINDER !== 8'd2) begin
         n_fail++;
         $display("FAIL basic_pulse_hold: done=%b q=%0d r=%0d, required done=0 q=14 r=2",
                  DONE, QUOTIENT, REMAINDER);
      end
   endtask

   task automatic test_boundaries;
      logic [W-1:0] vdvd [5] = '{8'd255, 8'd5, 8'd0,  8'd255, 8'd1};
      logic [W-1:0] vdvs [5] = '{8'd1,   8'd9, 8'd5,  8'd255, 8'd255};
      logic [W-1:0] vq   [5] = '{8'd255, 8'd0, 8'd0,  8'd1,   8'd0};
      logic [W-1:0] vr   [5] = '{8'd0,   8'd5, 8'd0,  8'd0,   8'd1};
      int lat;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         launch(vdvd[i], vdvs[i]);
         wait_done(lat);
         n_checks++;
         if (lat != 9 || QUOTIENT !== vq[i] || REMAINDER !== vr[i] || DIV_ZERO !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_%0d: %0d/%0d lat=%0d q=%0d r=%0d dz=%b, required lat=9 q=%0d r=%0d dz=0",
                     i, vdvd[i], vdvs[i], lat, QUOTIENT, REMAINDER, DIV_ZERO, vq[i], vr[i]);
         end
      end
   endtask

   task automatic test_div_zero;
      int lat;
      int exp_lat;
      logic exp_dz;
`ifdef DIV_ZERO_CHECK_EN
      exp_lat = 1;
      exp_dz  = 1'b1;
`else
      exp_lat = 9;
      exp_dz  = 1'b0;
`endif
      @(negedge CLK);
      launch(8'd37, 8'd0);
      wait_done(lat);
      n_checks++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL div_zero_latency: got %0d, required %0d", lat, exp_lat);
      end
      n_checks++;
      if (QUOTIENT !== 8'd255 || REMAINDER !== 8'd37 || DIV_ZERO !== exp_dz) begin
         n_fail++;
         $display("FAIL div_zero_result: q=%0d r=%0d dz=%b, required q=255 r=37 dz=%b",
                  QUOTIENT, REMAINDER, DIV_ZERO, exp_dz);
      end
      // A following normal op must clear the flag on its DONE edge.
      @(negedge CLK);
      launch(8'd12, 8'd5);
      wait_done(lat);
      n_checks++;
      if (lat != 9 || QUOTIENT !== 8'd2 || REMAINDER !== 8'd2 || DIV_ZERO !== 1'b0) begin
         n_fail++;
         $display("FAIL div_zero_clear: lat=%0d q=%0d r=%0d dz=%b, required lat=9 q=2 r=2 dz=0",
                  lat, QUOTIENT, REMAINDER, DIV_ZERO);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      // Previous result (12/5) must hold while the next op runs.
      @(negedge CLK);
      launch(8'd200, 8'd3);
      repeat (3) @(posedge CLK);
      #1;
      DIVIDEND = 8'd10;
      DIVISOR  = 8'd2;
      START    = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      n_checks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0 || QUOTIENT !== 8'd2 || REMAINDER !== 8'd2) begin
         n_fail++;
         $display("FAIL b2b_hold: busy=%b done=%b q=%0d r=%0d, required busy=1 done=0 q=2 r=2",
                  BUSY, DONE, QUOTIENT, REMAINDER);
      end
      lat = -1;
      for (int k = 5; k <= 40; k++) begin
         @(posedge CLK);
         #1;
         if (DONE === 1'b1) begin
            lat = k;
            break;
         end
      end
      n_checks++;
      if (lat != 9 || QUOTIENT !== 8'd66 || REMAINDER !== 8'd2) begin
         n_fail++;
         $display("FAIL b2b_ignore: lat=%0d q=%0d r=%0d, required lat=9 q=66 r=2",
                  lat, QUOTIENT, REMAINDER);
      end
      launch(8'd10, 8'd2);
      n_checks++;
      if (BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept_in_done: busy=%b, required 1", BUSY);
      end
      wait_done(lat);
      n_checks++;
      if (lat != 9 || QUOTIENT !== 8'd5 || REMAINDER !== 8'd0) begin
         n_fail++;
         $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, required lat=9 q=5 r=0",
                  lat, QUOTIENT, REMAINDER);
      end
   endtask

   task automatic test_mid_reset;
      int lat;
      @(negedge CLK);
      launch(8'd100, 8'd7);
      repeat (3) @(posedge CLK);
      #1;
      RST_BAR = 1'b0;
      @(posedge CLK);
      #1;
      n_checks++;
      if ({BUSY, DONE, DIV_ZERO, QUOTIENT, REMAINDER} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: busy=%b done=%b dz=%b q=%0d r=%0d, required all 0",
                  BUSY, DONE, DIV_ZERO, QUOTIENT, REMAINDER);
      end
      RST_BAR = 1'b1;
      launch(8'd9, 8'd4);
      n_checks++;
      if (BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_restart: busy=%b, required 1", BUSY);
      end
      wait_done(lat);
      n_checks++;
      if (lat != 9 || QUOTIENT !== 8'd2 || REMAINDER !== 8'd1) begin
         n_fail++;
         $display("FAIL mid_reset_result: lat=%0d q=%0d r=%0d, required lat=9 q=2 r=1",
                  lat, QUOTIENT, REMAINDER);
      end
   endtask

   task automatic test_sweep;
      int lat;
      logic [W-1:0] dvd;
      logic [W-1:0] dvs;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      for (int i = 0; i < 1000; i++) begin
         dvd = W'($urandom_range(0, 255));
         dvs = W'($urandom_range(0, 255));
         if (i % 50 == 0) dvs = '0;
         if (dvs == '0) begin
            eq = '1;
            er = dvd;
         end else begin
            eq = dvd / dvs;
            er = dvd % dvs;
         end
         @(negedge CLK);
         launch(dvd, dvs);
         wait_done(lat);
         n_checks++;
         if (lat < 0 || QUOTIENT !== eq || REMAINDER !== er) begin
            n_fail++;
            $display("FAIL sweep_%0d: %0d/%0d lat=%0d q=%0d r=%0d, required q=%0d r=%0d",
                     i, dvd, dvs, lat, QUOTIENT, REMAINDER, eq, er);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_basic();
      test_boundaries();
      test_div_zero();
      test_back_to_back();
      test_mid_reset();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
